// File: rtl/rc5_key_mixer_param_if.sv
// rtl/rc5_key_mixer_param_if.sv - start/done handshake plus S and L RAM ports of the RC5 key mixer
interface rc5_key_mixer_param_if #(
    parameter int W = 32,
    parameter int C = 4,
    parameter int T = 26
);
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int TW = $clog2(T);

    logic          iStart;
    logic          iInitS;
    logic          oBusy;
    logic          oDone;
    logic [TW-1:0] oS_addr;
    logic [W-1:0]  iS_rdata;
    logic [W-1:0]  oS_wdata;
    logic          oS_we;
    logic [CW-1:0] oL_addr;
    logic [W-1:0]  iL_rdata;
    logic [W-1:0]  oL_wdata;
    logic          oL_we;

    modport master (
        output iStart, iInitS, iS_rdata, iL_rdata,
        input  oBusy, oDone, oS_addr, oS_wdata, oS_we, oL_addr, oL_wdata, oL_we
    );

    modport slave (
        input  iStart, iInitS, iS_rdata, iL_rdata,
        output oBusy, oDone, oS_addr, oS_wdata, oS_we, oL_addr, oL_wdata, oL_we
    );
endinterface

// File: rtl/rc5_key_mixer_param.sv
// rtl/rc5_key_mixer_param.sv - parametrised RC5 key schedule: optional P/Q fill of S, then 3*max(T,C) mixing passes
module rc5_key_mixer_param #(
    parameter int W = 32,
    parameter int C = 4,
    parameter int T = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    rc5_key_mixer_param_if.slave  bus
);
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int TW = $clog2(T);
    localparam int N  = 3 * ((T > C) ? T : C);
    localparam int RW = $clog2(W);
    localparam int NW = $clog2(N);

    localparam logic [63:0] P64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                  (W == 32) ? 64'h0000_0000_B7E1_5163 : 64'hB7E1_5162_8AED_2A6B;
    localparam logic [63:0] Q64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                  (W == 32) ? 64'h0000_0000_9E37_79B9 : 64'h9E37_79B9_7F4A_7C15;
    localparam logic [W-1:0] P = P64[W-1:0];
    localparam logic [W-1:0] Q = Q64[W-1:0];

    if (!(W == 16 || W == 32 || W == 64)) begin : badWidth
        $error("rc5_key_mixer_param: W must be 16, 32 or 64");
    end

    typedef enum logic [2:0] {IDLE, INIT, ADDR, WAIT, MIX_S, MIX_L, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a, b, lData;
    logic [TW-1:0] i, k, iNext;
    logic [CW-1:0] j, jNext;
    logic [NW-1:0] cnt;
    logic [W-1:0]  sumAB, aMix, sumL, bMix;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] r);
        logic [2*W-1:0] d;
        d = {x, x} << r;
        return d[2*W-1:W];
    endfunction

    // aMix is registered leaving WAIT (S data valid then); bMix leaving MIX_S, after A has been updated
    always_comb begin
        sumAB = a + b;
        aMix  = rotl(bus.iS_rdata + sumAB, RW'(3));
        sumL  = lData + sumAB;
        bMix  = rotl(sumL, sumAB[RW-1:0]);
        iNext = (i == TW'(T - 1)) ? '0 : i + 1'b1;
        jNext = (j == CW'(C - 1)) ? '0 : j + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a            <= '0;
            b            <= '0;
            i            <= '0;
            j            <= '0;
            k            <= '0;
            cnt          <= '0;
            lData        <= '0;
            bus.oBusy    <= 1'b0;
            bus.oDone    <= 1'b0;
            bus.oS_addr  <= '0;
            bus.oS_wdata <= '0;
            bus.oS_we    <= 1'b0;
            bus.oL_addr  <= '0;
            bus.oL_wdata <= '0;
            bus.oL_we    <= 1'b0;
        end else begin
            bus.oS_we <= 1'b0;
            bus.oL_we <= 1'b0;
            bus.oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        a           <= '0;
                        b           <= '0;
                        i           <= '0;
                        j           <= '0;
                        k           <= '0;
                        cnt         <= '0;
                        bus.oBusy   <= 1'b1;
                        bus.oS_addr <= '0;
                        bus.oL_addr <= '0;
                        if (bus.iInitS) begin
                            state        <= INIT;
                            bus.oS_wdata <= P;
                            bus.oS_we    <= 1'b1;
                        end else begin
                            state <= ADDR;
                        end
                    end
                end
                INIT: begin
                    if (k == TW'(T - 1)) begin
                        state       <= ADDR;
                        bus.oS_addr <= i;
                        bus.oL_addr <= j;
                    end else begin
                        k            <= k + 1'b1;
                        bus.oS_addr  <= k + 1'b1;
                        bus.oS_wdata <= bus.oS_wdata + Q;
                        bus.oS_we    <= 1'b1;
                    end
                end
                ADDR: state <= WAIT;
                WAIT: begin
                    state        <= MIX_S;
                    lData        <= bus.iL_rdata;
                    a            <= aMix;
                    bus.oS_wdata <= aMix;
                    bus.oS_we    <= 1'b1;
                end
                MIX_S: begin
                    state        <= MIX_L;
                    b            <= bMix;
                    bus.oL_wdata <= bMix;
                    bus.oL_we    <= 1'b1;
                end
                MIX_L: begin
                    i           <= iNext;
                    j           <= jNext;
                    bus.oS_addr <= iNext;
                    bus.oL_addr <= jNext;
                    cnt         <= cnt + 1'b1;
                    if (cnt == NW'(N - 1)) begin
                        state     <= DONE;
                        bus.oDone <= 1'b1;
                    end else begin
                        state <= ADDR;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    bus.oBusy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc5_key_mixer_param.sv
// tb/tb_rc5_key_mixer_param.sv - self-checking bench for rc5_key_mixer_param at W=16/32/64 against a C-style key schedule model
module tb_rc5_key_mixer_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    rc5_key_mixer_param_if #(.W(16), .C(8), .T(26)) b16 ();
    rc5_key_mixer_param_if #(.W(32), .C(4), .T(26)) b32 ();
    rc5_key_mixer_param_if #(.W(64), .C(2), .T(34)) b64 ();

    rc5_key_mixer_param #(.W(16), .C(8), .T(26)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
    rc5_key_mixer_param #(.W(32), .C(4), .T(26)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
    rc5_key_mixer_param #(.W(64), .C(2), .T(34)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

    // RAM models: 1-cycle read latency, a staging load port, and a write log with running counts
    logic [15:0] sram16[0:31], sStage16[0:31], lram16[0:7], lStage16[0:7], sLog16[0:511], lLog16[0:511];
    logic [31:0] sram32[0:31], sStage32[0:31], lram32[0:3], lStage32[0:3], sLog32[0:511], lLog32[0:511];
    logic [63:0] sram64[0:63], sStage64[0:63], lram64[0:1], lStage64[0:1], sLog64[0:511], lLog64[0:511];
    logic ld16 = 1'b0, ld32 = 1'b0, ld64 = 1'b0;
    int sWr16 = 0, lWr16 = 0, sWr32 = 0, lWr32 = 0, sWr64 = 0, lWr64 = 0;

    always @(posedge clk) begin
        b16.iS_rdata <= sram16[b16.oS_addr];
        b16.iL_rdata <= lram16[b16.oL_addr];
        if (ld16) begin
            for (int n = 0; n < 32; n++) sram16[n] <= sStage16[n];
            for (int n = 0; n < 8; n++) lram16[n] <= lStage16[n];
        end else begin
            if (b16.oS_we) begin sram16[b16.oS_addr] <= b16.oS_wdata; sLog16[sWr16 % 512] <= b16.oS_wdata; sWr16 <= sWr16 + 1; end
            if (b16.oL_we) begin lram16[b16.oL_addr] <= b16.oL_wdata; lLog16[lWr16 % 512] <= b16.oL_wdata; lWr16 <= lWr16 + 1; end
        end
    end

    always @(posedge clk) begin
        b32.iS_rdata <= sram32[b32.oS_addr];
        b32.iL_rdata <= lram32[b32.oL_addr];
        if (ld32) begin
            for (int n = 0; n < 32; n++) sram32[n] <= sStage32[n];
            for (int n = 0; n < 4; n++) lram32[n] <= lStage32[n];
        end else begin
            if (b32.oS_we) begin sram32[b32.oS_addr] <= b32.oS_wdata; sLog32[sWr32 % 512] <= b32.oS_wdata; sWr32 <= sWr32 + 1; end
            if (b32.oL_we) begin lram32[b32.oL_addr] <= b32.oL_wdata; lLog32[lWr32 % 512] <= b32.oL_wdata; lWr32 <= lWr32 + 1; end
        end
    end

    always @(posedge clk) begin
        b64.iS_rdata <= sram64[b64.oS_addr];
        b64.iL_rdata <= lram64[b64.oL_addr];
        if (ld64) begin
            for (int n = 0; n < 64; n++) sram64[n] <= sStage64[n];
            for (int n = 0; n < 2; n++) lram64[n] <= lStage64[n];
        end else begin
            if (b64.oS_we) begin sram64[b64.oS_addr] <= b64.oS_wdata; sLog64[sWr64 % 512] <= b64.oS_wdata; sWr64 <= sWr64 + 1; end
            if (b64.oL_we) begin lram64[b64.oL_addr] <= b64.oL_wdata; lLog64[lWr64 % 512] <= b64.oL_wdata; lWr64 <= lWr64 + 1; end
        end
    end

    // Reference key schedule, straight from the RC5 algorithm description
    logic [63:0] mS[0:63];
    logic [63:0] mL[0:15];

    function automatic logic [63:0] mmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] mrotl(input logic [63:0] x, input int r, input int w);
        if (r == 0) return x;
        return ((x << r) | (x >> (w - r))) & mmask(w);
    endfunction

    function automatic logic [63:0] pconst(input int w);
        return (w == 16) ? 64'hB7E1 : (w == 32) ? 64'hB7E1_5163 : 64'hB7E1_5162_8AED_2A6B;
    endfunction

    function automatic logic [63:0] qconst(input int w);
        return (w == 16) ? 64'h9E37 : (w == 32) ? 64'h9E37_79B9 : 64'h9E37_79B9_7F4A_7C15;
    endfunction

    task automatic model_run(input int w, input int t, input int c, input bit initS);
        logic [63:0] m, aa, bb;
        int ii, jj;
        m = mmask(w);
        if (initS) for (int n = 0; n < t; n++) mS[n] = (pconst(w) + 64'(n) * qconst(w)) & m;
        aa = 0; bb = 0; ii = 0; jj = 0;
        for (int n = 0; n < 3 * ((t > c) ? t : c); n++) begin
            aa = mrotl((mS[ii] + aa + bb) & m, 3, w);
            mS[ii] = aa;
            bb = mrotl((mL[jj] + aa + bb) & m, int'((aa + bb) % 64'(w)), w);
            mL[jj] = bb;
            ii = (ii + 1) % t;
            jj = (jj + 1) % c;
        end
    endtask

    task automatic load16();
        for (int n = 0; n < 32; n++) sStage16[n] = 16'($urandom);
        for (int n = 0; n < 8; n++) lStage16[n] = 16'($urandom);
        @(negedge clk); ld16 = 1'b1;
        @(negedge clk); ld16 = 1'b0;
    endtask

    task automatic load32(input bit zeroL);
        for (int n = 0; n < 32; n++) sStage32[n] = $urandom;
        for (int n = 0; n < 4; n++) lStage32[n] = zeroL ? 32'd0 : $urandom;
        @(negedge clk); ld32 = 1'b1;
        @(negedge clk); ld32 = 1'b0;
    endtask

    task automatic load64();
        for (int n = 0; n < 64; n++) sStage64[n] = {$urandom, $urandom};
        for (int n = 0; n < 2; n++) lStage64[n] = {$urandom, $urandom};
        @(negedge clk); ld64 = 1'b1;
        @(negedge clk); ld64 = 1'b0;
    endtask

    // Start sampled at edge 0; cyc counts edges so that the observation after edge 0 is cycle 1
    task automatic run16(input bit initS, output int cyc);
        @(negedge clk); b16.iInitS = initS; b16.iStart = 1'b1;
        @(posedge clk); #1; b16.iStart = 1'b0; cyc = 1;
        while (!b16.oDone && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic run32(input bit initS, output int cyc);
        @(negedge clk); b32.iInitS = initS; b32.iStart = 1'b1;
        @(posedge clk); #1; b32.iStart = 1'b0; cyc = 1;
        while (!b32.oDone && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic run64(input bit initS, output int cyc);
        @(negedge clk); b64.iInitS = initS; b64.iStart = 1'b1;
        @(posedge clk); #1; b64.iStart = 1'b0; cyc = 1;
        while (!b64.oDone && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({b16.oBusy, b16.oDone, b16.oS_we, b16.oL_we, b16.oS_addr, b16.oL_addr, b16.oS_wdata, b16.oL_wdata} !== '0) begin
            errors++; $display("FAIL reset_w16 outputs got %b want all zero", {b16.oBusy, b16.oDone, b16.oS_we, b16.oL_we}); end
        checks++;
        if ({b32.oBusy, b32.oDone, b32.oS_we, b32.oL_we, b32.oS_addr, b32.oL_addr, b32.oS_wdata, b32.oL_wdata} !== '0) begin
            errors++; $display("FAIL reset_w32 outputs got %b want all zero", {b32.oBusy, b32.oDone, b32.oS_we, b32.oL_we}); end
        checks++;
        if ({b64.oBusy, b64.oDone, b64.oS_we, b64.oL_we, b64.oS_addr, b64.oL_addr, b64.oS_wdata, b64.oL_wdata} !== '0) begin
            errors++; $display("FAIL reset_w64 outputs got %b want all zero", {b64.oBusy, b64.oDone, b64.oS_we, b64.oL_we}); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_init_w32();
        int cyc, sb, lb;
        load32(1'b1);
        for (int n = 0; n < 26; n++) mS[n] = 64'(sram32[n]);
        for (int n = 0; n < 4; n++) mL[n] = 64'(lram32[n]);
        sb = sWr32; lb = lWr32;
        run32(1'b1, cyc);
        model_run(32, 26, 4, 1'b1);
        checks++; if (cyc !== 339) begin errors++; $display("FAIL t1_done_cycle got %0d want 339", cyc); end
        checks++; if (b32.oBusy !== 1'b1) begin errors++; $display("FAIL t1_busy_at_done got %b want 1", b32.oBusy); end
        checks++; if (sWr32 - sb !== 104) begin errors++; $display("FAIL t1_s_writes got %0d want 104", sWr32 - sb); end
        checks++; if (lWr32 - lb !== 78) begin errors++; $display("FAIL t1_l_writes got %0d want 78", lWr32 - lb); end
        checks++; if (sLog32[sb % 512] !== 32'hB7E1_5163) begin errors++; $display("FAIL t1_init_s0 got %h want b7e15163", sLog32[sb % 512]); end
        checks++; if (sLog32[(sb + 1) % 512] !== 32'h5618_CB1C) begin errors++; $display("FAIL t1_init_s1 got %h want 5618cb1c", sLog32[(sb + 1) % 512]); end
        checks++; if (sLog32[(sb + 26) % 512] !== 32'hBF0A_8B1D) begin errors++; $display("FAIL t2_first_mix_s got %h want bf0a8b1d", sLog32[(sb + 26) % 512]); end
        checks++; if (lLog32[lb % 512] !== 32'hB7E1_5163) begin errors++; $display("FAIL t2_first_mix_l got %h want b7e15163", lLog32[lb % 512]); end
        @(posedge clk); #1;
        checks++; if ({b32.oDone, b32.oBusy} !== 2'b00) begin errors++; $display("FAIL t1_after_done done,busy got %b want 00", {b32.oDone, b32.oBusy}); end
        for (int n = 0; n < 26; n++) begin
            checks++; if (sram32[n] !== mS[n][31:0]) begin errors++; $display("FAIL t1_S[%0d] got %h want %h", n, sram32[n], mS[n][31:0]); end
        end
        for (int n = 0; n < 4; n++) begin
            checks++; if (lram32[n] !== mL[n][31:0]) begin errors++; $display("FAIL t1_L[%0d] got %h want %h", n, lram32[n], mL[n][31:0]); end
        end
    endtask

    task automatic test_w16_random_key();
        int cyc, sb, lb;
        load16();
        for (int n = 0; n < 26; n++) mS[n] = 64'(sram16[n]);
        for (int n = 0; n < 8; n++) mL[n] = 64'(lram16[n]);
        sb = sWr16; lb = lWr16;
        run16(1'b1, cyc);
        model_run(16, 26, 8, 1'b1);
        checks++; if (cyc - 27 !== 312) begin errors++; $display("FAIL t3_mix_cycles got %0d want 312", cyc - 27); end
        checks++; if (sLog16[(sb + 1) % 512] !== 16'h5618) begin errors++; $display("FAIL t3_init_s1 got %h want 5618", sLog16[(sb + 1) % 512]); end
        checks++; if (lWr16 - lb !== 78) begin errors++; $display("FAIL t3_l_writes got %0d want 78", lWr16 - lb); end
        for (int n = 0; n < 26; n++) begin
            checks++; if (sram16[n] !== mS[n][15:0]) begin errors++; $display("FAIL t3_S[%0d] got %h want %h", n, sram16[n], mS[n][15:0]); end
        end
        for (int n = 0; n < 8; n++) begin
            checks++; if (lram16[n] !== mL[n][15:0]) begin errors++; $display("FAIL t3_L[%0d] got %h want %h", n, lram16[n], mL[n][15:0]); end
        end
    endtask

    task automatic test_w64_noinit();
        int cyc, sb, lb;
        load64();
        for (int n = 0; n < 34; n++) mS[n] = sram64[n];
        for (int n = 0; n < 2; n++) mL[n] = lram64[n];
        sb = sWr64; lb = lWr64;
        run64(1'b0, cyc);
        model_run(64, 34, 2, 1'b0);
        checks++; if (cyc !== 409) begin errors++; $display("FAIL t4_done_cycle got %0d want 409", cyc); end
        checks++; if (sWr64 - sb !== 102) begin errors++; $display("FAIL t4_s_writes got %0d want 102", sWr64 - sb); end
        checks++; if (lWr64 - lb !== 102) begin errors++; $display("FAIL t4_l_writes got %0d want 102", lWr64 - lb); end
        for (int n = 0; n < 34; n++) begin
            checks++; if (sram64[n] !== mS[n]) begin errors++; $display("FAIL t4_S[%0d] got %h want %h", n, sram64[n], mS[n]); end
        end
        for (int n = 0; n < 2; n++) begin
            checks++; if (lram64[n] !== mL[n]) begin errors++; $display("FAIL t4_L[%0d] got %h want %h", n, lram64[n], mL[n]); end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, sb, lb, seen, target, n;
        load32(1'b0);
        target = $urandom_range(3, 20);
        @(negedge clk); b32.iInitS = 1'b1; b32.iStart = 1'b1;
        @(posedge clk); #1; b32.iStart = 1'b0;
        seen = 0; n = 0;
        while (seen < target && n < 3000) begin
            @(posedge clk); #1; n++;
            if (b32.oL_we) seen++;
        end
        checks++; if (seen !== target) begin errors++; $display("FAIL t5_reach_mix_l got %0d want %0d", seen, target); end
        rst = 1'b1;
        @(posedge clk); #1;
        sb = sWr32; lb = lWr32;
        checks++; if ({b32.oBusy, b32.oS_we, b32.oL_we, b32.oDone} !== 4'b0000) begin
            errors++; $display("FAIL t5_abort busy,swe,lwe,done got %b want 0000", {b32.oBusy, b32.oS_we, b32.oL_we, b32.oDone}); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if ((sWr32 - sb) + (lWr32 - lb) !== 0) begin errors++; $display("FAIL t5_writes_in_reset got %0d want 0", (sWr32 - sb) + (lWr32 - lb)); end
        @(negedge clk); rst = 1'b0;
        for (int m = 0; m < 26; m++) mS[m] = 64'(sram32[m]);
        for (int m = 0; m < 4; m++) mL[m] = 64'(lram32[m]);
        run32(1'b0, cyc);
        model_run(32, 26, 4, 1'b0);
        checks++; if (cyc !== 313) begin errors++; $display("FAIL t5_rerun_done_cycle got %0d want 313", cyc); end
        for (int m = 0; m < 26; m++) begin
            checks++; if (sram32[m] !== mS[m][31:0]) begin errors++; $display("FAIL t5_S[%0d] got %h want %h", m, sram32[m], mS[m][31:0]); end
        end
        for (int m = 0; m < 4; m++) begin
            checks++; if (lram32[m] !== mL[m][31:0]) begin errors++; $display("FAIL t5_L[%0d] got %h want %h", m, lram32[m], mL[m][31:0]); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit busyDrop;
        for (int n = 0; n < 26; n++) mS[n] = 64'(sram16[n]);
        for (int n = 0; n < 8; n++) mL[n] = 64'(lram16[n]);
        @(negedge clk); b16.iInitS = 1'b1; b16.iStart = 1'b1;
        @(posedge clk); #1; cyc = 1; busyDrop = 1'b0;
        while (!b16.oDone && cyc < 3000) begin
            if (!b16.oBusy) busyDrop = 1'b1;
            @(posedge clk); #1; cyc++;
        end
        model_run(16, 26, 8, 1'b1);
        checks++; if (cyc !== 339) begin errors++; $display("FAIL t6_first_done_cycle got %0d want 339", cyc); end
        checks++; if (busyDrop !== 1'b0) begin errors++; $display("FAIL t6_busy_dropped got %b want 0", busyDrop); end
        @(posedge clk); #1;
        checks++; if (b16.oBusy !== 1'b0) begin errors++; $display("FAIL t6_idle_gap busy got %b want 0", b16.oBusy); end
        @(posedge clk); #1;
        checks++; if ({b16.oBusy, b16.oS_we, b16.oS_addr} !== {2'b11, 5'd0}) begin
            errors++; $display("FAIL t6_restart busy,we,addr got %b want 1100000", {b16.oBusy, b16.oS_we, b16.oS_addr}); end
        b16.iStart = 1'b0; cyc = 1;
        while (!b16.oDone && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        model_run(16, 26, 8, 1'b1);
        checks++; if (cyc !== 339) begin errors++; $display("FAIL t6_second_done_cycle got %0d want 339", cyc); end
        for (int n = 0; n < 26; n++) begin
            checks++; if (sram16[n] !== mS[n][15:0]) begin errors++; $display("FAIL t6_S[%0d] got %h want %h", n, sram16[n], mS[n][15:0]); end
        end
        for (int n = 0; n < 8; n++) begin
            checks++; if (lram16[n] !== mL[n][15:0]) begin errors++; $display("FAIL t6_L[%0d] got %h want %h", n, lram16[n], mL[n][15:0]); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b16.iStart = 1'b0; b16.iInitS = 1'b0;
        b32.iStart = 1'b0; b32.iInitS = 1'b0;
        b64.iStart = 1'b0; b64.iInitS = 1'b0;
        test_reset();
        test_init_w32();
        test_w16_random_key();
        test_w64_noinit();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
